// File: rtl/shift_add_mult_ctrl_pkg.sv
// Shared types and sizing helpers for the sequential shift-add multiplier.
package mult_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} mult_state_e;

    // Iteration counter must hold the value N itself (terminal count).
    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/shift_add_mult_ctrl_if.sv
// Request/response handshake bundle between the execute stage and the multiplier.
interface shift_add_mult_ctrl_if #(
    parameter int N = 32
) ();
    logic           req_valid;
    logic           req_ready;
    logic [N-1:0]   req_a;
    logic [N-1:0]   req_b;
    logic           res_valid;
    logic           res_ready;
    logic [2*N-1:0] res_p;
    logic           busy;

    modport master (
        output req_valid, req_a, req_b, res_ready,
        input  req_ready, res_valid, res_p, busy
    );

    modport slave (
        input  req_valid, req_a, req_b, res_ready,
        output req_ready, res_valid, res_p, busy
    );
endinterface

// File: rtl/shift_add_mult_ctrl_adder.sv
// Parameterised N-bit ripple-carry adder built from a full-adder chain.
// Purely combinational; carry ripples LSB to MSB.
module shift_add_mult_ctrl_adder #(
    parameter int N = 32
) (
    input  logic [N-1:0] i_a,
    input  logic [N-1:0] i_b,
    input  logic         i_cin,
    output logic [N-1:0] o_sum,
    output logic         o_cout
);
    logic [N:0] w_c;

    assign w_c[0] = i_cin;

    for (genvar g = 0; g < N; g++) begin : g_fa
        assign o_sum[g]  = i_a[g] ^ i_b[g] ^ w_c[g];
        assign w_c[g+1]  = (i_a[g] & i_b[g]) | (w_c[g] & (i_a[g] ^ i_b[g]));
    end

    assign o_cout = w_c[N];
endmodule

// File: rtl/shift_add_mult_ctrl.sv
// Sequential unsigned N x N -> 2N multiplier: one shared adder, N shift-add steps, latency N+1.
// Optional macro MULT_EARLY_ZERO_EN short-circuits zero operands to a 1-cycle result.
module shift_add_mult_ctrl
    import mult_pkg::*;
#(
    parameter int N = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    shift_add_mult_ctrl_if.slave bus
);
    localparam int                CNT_W = cnt_w(N);
    localparam logic [CNT_W-1:0]  CNT_N = CNT_W'(N);

`ifdef MULT_EARLY_ZERO_EN
    localparam bit EARLY_ZERO = 1'b1;
`else
    localparam bit EARLY_ZERO = 1'b0;
`endif

    mult_state_e      r_state;
    logic [N-1:0]     r_acc_hi;
    logic [N-1:0]     r_acc_lo;
    logic [N-1:0]     r_mcand;
    logic [CNT_W-1:0] r_count;
    logic             r_req_ready;
    logic             r_res_valid;
    logic             r_busy;

    logic [N-1:0]     w_addend;
    logic [N-1:0]     w_sum;
    logic             w_cout;
    logic             w_zero_op;

    assign w_addend  = r_acc_lo[0] ? r_mcand : '0;
    assign w_zero_op = EARLY_ZERO && ((bus.req_a == '0) || (bus.req_b == '0));

    shift_add_mult_ctrl_adder #(.N(N)) u_adder (
        .i_a    (r_acc_hi),
        .i_b    (w_addend),
        .i_cin  (1'b0),
        .o_sum  (w_sum),
        .o_cout (w_cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_acc_hi    <= '0;
            r_acc_lo    <= '0;
            r_mcand     <= '0;
            r_count     <= '0;
            r_req_ready <= 1'b1;
            r_res_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.req_valid) begin
                        r_state     <= RUN;
                        r_mcand     <= bus.req_a;
                        r_acc_hi    <= '0;
                        r_req_ready <= 1'b0;
                        r_busy      <= 1'b1;
                        // Zero operand: skip the iterations, spend one cycle to reach DONE.
                        if (w_zero_op) begin
                            r_acc_lo <= '0;
                            r_count  <= CNT_N;
                        end else begin
                            r_acc_lo <= bus.req_b;
                            r_count  <= '0;
                        end
                    end
                end
                RUN: begin
                    if (r_count == CNT_N) begin
                        r_state     <= DONE;
                        r_res_valid <= 1'b1;
                    end else begin
                        {r_acc_hi, r_acc_lo} <= {w_cout, w_sum, r_acc_lo[N-1:1]};
                        r_count              <= r_count + 1'b1;
                    end
                end
                DONE: begin
                    if (bus.res_ready) begin
                        r_state     <= IDLE;
                        r_res_valid <= 1'b0;
                        r_req_ready <= 1'b1;
                        r_busy      <= 1'b0;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.req_ready = r_req_ready;
    assign bus.res_valid = r_res_valid;
    assign bus.res_p     = {r_acc_hi, r_acc_lo};
    assign bus.busy      = r_busy;
endmodule
